// File: rtl/switch_reader_pkg.sv
// Shared constants for the switch/button read-back block.
// Read-select encodings and the default sampling period.
package switch_reader_pkg;
  localparam int CONF_DATA_W = 16;
  localparam logic RSEL_SW = 1'b0;
  localparam logic RSEL_BTN = 1'b1;
  localparam int DEBOUNCE_DEFAULT = 50000;
endpackage

// File: rtl/switch_reader_debounce_bit.sv
// One input bit: two-flop synchroniser, tick sample, stable level.
// A level is accepted once two consecutive ticks agree.
module debounce_bit
  import switch_reader_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o
);
  logic sync1_q, sync2_q;
  logic samp_q, samp_d;
  logic stab_q, stab_d;

  always_comb begin
    samp_d = samp_q;
    stab_d = stab_q;
    if (tick_i) begin
      samp_d = sync2_q;
      if (sync2_q == samp_q) stab_d = sync2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 1'b0;
      stab_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      stab_q  <= stab_d;
    end
  end

  assign stable_o = stab_q;
endmodule

// File: rtl/switch_reader.sv
// Debounced DIP switches and sticky button events,
// returned through a registered one-cycle read port.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int N_BTN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CONF_DATA_W-1:0] switches,
  input  logic [N_BTN-1:0]       btns,
  input  logic                   conf_ren,
  input  logic                   conf_rsel,
  output logic [CONF_DATA_W-1:0] conf_rdata,
  output logic                   conf_rvalid
);
  localparam int NB = CONF_DATA_W + N_BTN;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  logic [NB-1:0] raw, db;
  logic [CONF_DATA_W-1:0] sw_db;
  logic [N_BTN-1:0] btn_db, btn_prev_q, btn_rise;
  logic [N_BTN-1:0] ev_q, ev_d;
  logic [CONF_DATA_W-1:0] ev_ext;

  logic [CONF_DATA_W-1:0] rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;

  assign raw    = {btns, switches};
  assign sw_db  = db[CONF_DATA_W-1:0];
  assign btn_db = db[NB-1:CONF_DATA_W];

  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_bit u_db (
      .clk_i   (clk),
      .reset_i (reset),
      .tick_i  (tick),
      .raw_i   (raw[i]),
      .stable_o(db[i])
    );
  end

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // A rise landing on a clearing read wins, so no press is lost.
  always_comb begin
    btn_rise = btn_db & ~btn_prev_q;
    ev_ext = '0;
    ev_ext[N_BTN-1:0] = ev_q;
    ev_d = ev_q;
    if (conf_ren && conf_rsel == RSEL_BTN) ev_d = '0;
    ev_d = ev_d | btn_rise;
    rvalid_d = conf_ren;
    rdata_d  = rdata_q;
    if (conf_ren)
      rdata_d = (conf_rsel == RSEL_BTN) ? ev_ext : sw_db;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      btn_prev_q <= '0;
      ev_q       <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_db;
      ev_q       <= ev_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign conf_rdata  = rdata_q;
  assign conf_rvalid = rvalid_q;
endmodule

// File: doc/switch_reader.md
# switch_reader

Input-side companion to the LED configuration register: samples the board's 16 DIP switches and 4 push buttons, synchronises and debounces them, latches button presses as sticky events, and returns either value to the CPU through a registered read port. It sits beside the LED write register in the verification top level, with switch/button pins on one side and the CPU's configuration read path on the other.

## Interface
- DEBOUNCE_CYCLES, default 50000: sampling-tick period in clk cycles; legal range 2..2^20.
- N_BTN, default 4: number of push buttons; legal range 1..16.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- switches  input  16  raw asynchronous DIP switch levels.
- btns  input  N_BTN  raw asynchronous push-button levels, 1 = pressed.
- conf_ren  input  1  read request, sampled on each rising clk edge.
- conf_rsel  input  1  0 = debounced switch value, 1 = button event flags.
- conf_rdata  output  16  read data.
- conf_rvalid  output  1  one-cycle pulse marking conf_rdata valid.

## Operation
- Synchroniser: two flip-flops per input bit (16 + N_BTN); reset value 0.
- Tick generator: free-running counter over 0..DEBOUNCE_CYCLES-1, width $clog2(DEBOUNCE_CYCLES). tick = 1 when the counter equals DEBOUNCE_CYCLES-1, then the counter wraps to 0. Reset value 0.
- Debounce, per bit, on tick only:
  - Compare the synchronised level with that bit's previous tick sample.
  - If they are equal, the debounced bit takes that level.
  - Always store the new sample.
  - Net rule: a level must be seen on two consecutive ticks to be accepted.
  - Sample and debounced registers reset to 0.
- Button events:
  - A 0→1 transition of a debounced button sets its sticky flag ev[i].
  - A read with conf_rsel=1 clears every flag that was returned.
  - If a rising edge and a clearing read hit the same bit in the same cycle, the flag stays set, so the event is not lost.
  - Flags reset to 0.
- Read port:
  - When conf_ren=1 at an edge, the next cycle gives conf_rvalid=1.
  - conf_rdata = debounced switches when conf_rsel=0.
  - conf_rdata = {(16-N_BTN)'b0, ev} when conf_rsel=1.
  - Data is captured from register state at the request edge.
  - conf_ren held high gives one response per cycle, back-to-back.
  - conf_rdata holds its last value while conf_rvalid=0.
- Reset values: conf_rdata = 16'h0000, conf_rvalid = 0, all internal state 0. Reset mid-read cancels the pending response: conf_rvalid stays 0 in the cycle after reset deasserts unless conf_ren is sampled again.

## Timing
- Read latency: exactly 1 cycle from the conf_ren edge to conf_rvalid/conf_rdata. No stall and no backpressure.
- Input-to-debounced latency: 2 synchroniser cycles, then acceptance at the second agreeing tick. For D = DEBOUNCE_CYCLES the range is 2 + D + 1 to 2 + 2D + 1 cycles, depending on tick phase.
- Glitch rejection: any pulse shorter than D cycles that does not span two ticks never reaches the debounced value.
- Event flag: sets 1 cycle after the debounced rising edge, and is visible to a read issued that same cycle or later.
- Clear-on-read: takes effect at the request edge, so a second read on the next cycle returns the flag as 0 unless a new edge occurred.
- Tick counter wrap: the count after DEBOUNCE_CYCLES-1 is 0, with no skipped or doubled tick.

## Structure
- Shared package: CONF_DATA_W = 16, the RSEL_SW = 1'b0 and RSEL_BTN = 1'b1 encodings, and the default DEBOUNCE_CYCLES.
- One sub-module: debounce_bit (synchroniser, tick sample, stable output). It is instantiated 16 + N_BTN times in a generate loop, with the tick shared from the top.
- Tick counter, event flags and read register live in switch_reader.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4, N_BTN = 4.
- Reset: hold reset 3 cycles with switches = 16'hFFFF → conf_rdata = 0 and conf_rvalid = 0 during reset; a read immediately after returns 16'h0000.
- Switch settle: switches = 16'hA5C3 held 20 cycles, then read with rsel=0 → one-cycle conf_rvalid, conf_rdata = 16'hA5C3 on the next cycle.
- Glitch rejection: switches[0] pulses to 1 for 3 cycles between ticks → no read over the next 20 cycles ever shows bit 0 set.
- Button event and clear: btns[2] pressed 12 cycles, released → rsel=1 read returns 16'h0004; an immediate second read returns 16'h0000.
- Simultaneous set/clear: force the btns[1] debounced rise in the same cycle as an rsel=1 read → that read returns bit 1 = 0, and the next read returns 16'h0002.
- Back-to-back reads and reset mid-read: conf_ren high 5 cycles with alternating rsel → 5 consecutive rvalid pulses with matching data; assert reset in the cycle after a request → no rvalid, outputs 0.
